// File: rtl/clk_period_monitor_if.sv
// Status bundle between the slow-clock monitor and its consumer.
// Latency: none (wires only).
// Backpressure: none; the monitored clock and err_clr are free-running inputs.
//
// Ports (modports):
//   master - stimulus/consumer side: drives clk_in, err_clr; reads the status outputs
//   slave  - monitor side: reads clk_in, err_clr; drives half_period, period_valid,
//            locked, err_high, err_low, timeout
interface clk_period_monitor_if #(
    parameter int CNT_W = 32
);
    logic             clk_in;
    logic             err_clr;
    logic [CNT_W-1:0] half_period;
    logic             period_valid;
    logic             locked;
    logic             err_high;
    logic             err_low;
    logic             timeout;

    modport master (
        output clk_in,
        output err_clr,
        input  half_period,
        input  period_valid,
        input  locked,
        input  err_high,
        input  err_low,
        input  timeout
    );

    modport slave (
        input  clk_in,
        input  err_clr,
        output half_period,
        output period_valid,
        output locked,
        output err_high,
        output err_low,
        output timeout
    );
endinterface

// File: rtl/clk_period_monitor.sv
// Measures edge-to-edge distance of a slow clock in clk100MHz cycles; flags lock, range errors, stop.
// Latency: edge seen 3 cycles after clk_in changes; all outputs registered 1 cycle after edge detect.
// Backpressure: none; period_valid is a one-cycle pulse that is not held for the consumer.
//
// Ports:
//   clk100MHz - system clock
//   rst       - synchronous active-high reset
//   bus       - slave modport: clk_in, err_clr in; half_period, period_valid, locked,
//               err_high, err_low, timeout out
module clk_period_monitor #(
    parameter int CNT_W    = 32,
    parameter int EXP_HALF = 10000,
    parameter int TOL      = 2,
    parameter int LOCK_N   = 4,
    parameter int TIMEOUT  = 40000
) (
    input  logic                 clk100MHz,
    input  logic                 rst,
    clk_period_monitor_if.slave  bus
);
    localparam int GC_W = $clog2(LOCK_N + 1);
    localparam logic [CNT_W-1:0] LIM_LO  = CNT_W'(EXP_HALF - TOL);
    localparam logic [CNT_W-1:0] LIM_HI  = CNT_W'(EXP_HALF + TOL);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [GC_W-1:0]  GOOD_N  = GC_W'(LOCK_N);

    typedef enum logic [1:0] {IDLE, MEASURE, LOCKED} state_t;

    state_t           state_q, state_d;
    logic             sync1_q, sync2_q, dly_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [GC_W-1:0]  good_q, good_d;
    logic [CNT_W-1:0] half_q, half_d;
    logic             pv_q, pv_d;
    logic             locked_q, locked_d;
    logic             errh_q, errh_d;
    logic             errl_q, errl_d;
    logic             to_q, to_d;

    logic             edge_det;
    logic [CNT_W-1:0] measured;
    logic             in_range;
    logic             too_high;
    logic             new_hi, new_lo, new_to;

    // Both polarities count: the slow clock's half-period is what is being measured.
    assign edge_det = sync2_q ^ dly_q;
    // cnt is zero in the cycle after an edge, so the edge-to-edge distance is cnt+1.
    assign measured = cnt_q + CNT_W'(1);
    assign in_range = (measured >= LIM_LO) && (measured <= LIM_HI);
    assign too_high = (measured > LIM_HI);

    always_comb begin
        state_d  = state_q;
        good_d   = good_q;
        half_d   = half_q;
        pv_d     = 1'b0;
        locked_d = locked_q;
        new_hi   = 1'b0;
        new_lo   = 1'b0;
        new_to   = 1'b0;

        if (edge_det) begin
            cnt_d = '0;
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end

        case (state_q)
            IDLE: begin
                // The first edge has no reference point; it only starts timing.
                cnt_d = '0;
                if (edge_det) begin
                    state_d = MEASURE;
                end
            end
            MEASURE, LOCKED: begin
                if (edge_det) begin
                    half_d = measured;
                    pv_d   = 1'b1;
                    if (in_range) begin
                        if (state_q == MEASURE) begin
                            good_d = good_q + GC_W'(1);
                            if (good_d == GOOD_N) begin
                                state_d  = LOCKED;
                                locked_d = 1'b1;
                            end
                        end
                    end else begin
                        good_d   = '0;
                        locked_d = 1'b0;
                        state_d  = MEASURE;
                        new_hi   = too_high;
                        new_lo   = ~too_high;
                    end
                end else if (cnt_q == TO_LAST) begin
                    // An edge in this same cycle takes the branch above instead.
                    new_to   = 1'b1;
                    locked_d = 1'b0;
                    good_d   = '0;
                    cnt_d    = '0;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A fresh error outranks a clear arriving in the same cycle.
        errh_d = (errh_q & ~bus.err_clr) | new_hi;
        errl_d = (errl_q & ~bus.err_clr) | new_lo;
        to_d   = (to_q   & ~bus.err_clr) | new_to;
    end

    always_ff @(posedge clk100MHz) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            dly_q    <= 1'b0;
            state_q  <= IDLE;
            cnt_q    <= '0;
            good_q   <= '0;
            half_q   <= '0;
            pv_q     <= 1'b0;
            locked_q <= 1'b0;
            errh_q   <= 1'b0;
            errl_q   <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            sync1_q  <= bus.clk_in;
            sync2_q  <= sync1_q;
            dly_q    <= sync2_q;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            good_q   <= good_d;
            half_q   <= half_d;
            pv_q     <= pv_d;
            locked_q <= locked_d;
            errh_q   <= errh_d;
            errl_q   <= errl_d;
            to_q     <= to_d;
        end
    end

    assign bus.half_period  = half_q;
    assign bus.period_valid = pv_q;
    assign bus.locked       = locked_q;
    assign bus.err_high     = errh_q;
    assign bus.err_low      = errl_q;
    assign bus.timeout      = to_q;
endmodule

// File: tb/tb_clk_period_monitor.sv
// Bench for clk_period_monitor with the nominal period and timeout scaled down 100x.
// Latency: n/a.
// Backpressure: n/a.
module tb_clk_period_monitor;
    localparam int CNT_W    = 32;
    localparam int EXP_HALF = 100;
    localparam int TOL      = 2;
    localparam int LOCK_N   = 4;
    localparam int TIMEOUT  = 400;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    clk_period_monitor_if #(.CNT_W(CNT_W)) bus ();

    clk_period_monitor #(
        .CNT_W    (CNT_W),
        .EXP_HALF (EXP_HALF),
        .TOL      (TOL),
        .LOCK_N   (LOCK_N),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk100MHz (clk),
        .rst       (rst),
        .bus       (bus.slave)
    );

    int   vectors     = 0;
    int   miscompares = 0;
    int   exp_q[$];
    int   elapsed     = 0;
    logic prev_pv     = 1'b0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    // Scoreboard side: every period_valid consumes one expected measurement.
    always @(posedge clk) begin
        #1;
        if (bus.period_valid) begin
            chk("pv_width", 32'(prev_pv), 32'd0);
            if (exp_q.size() > 0)
                chk("half_period", bus.half_period, 32'(exp_q.pop_front()));
            else
                chk("pv_unexpected", 32'(bus.period_valid), 32'd0);
        end
        prev_pv = bus.period_valid;
    end

    task automatic tick();
        @(negedge clk);
        elapsed++;
    endtask

    // Toggle clk_in d cycles after the previous toggle, then let the result settle.
    // clr_at_edge raises err_clr exactly in the DUT's edge-detect cycle.
    task automatic step(input int d, input bit meas, input bit clr_at_edge);
        while (elapsed < d) tick();
        bus.clk_in = ~bus.clk_in;
        elapsed = 0;
        if (meas) exp_q.push_back(d);
        tick();
        tick();
        if (clr_at_edge) bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        tick();
        tick();
    endtask

    task automatic pulse_clr();
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        tick();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_half"},   bus.half_period,         32'd0);
        chk({tag, "_pv"},     32'(bus.period_valid),   32'd0);
        chk({tag, "_locked"}, 32'(bus.locked),         32'd0);
        chk({tag, "_errh"},   32'(bus.err_high),       32'd0);
        chk({tag, "_errl"},   32'(bus.err_low),        32'd0);
        chk({tag, "_to"},     32'(bus.timeout),        32'd0);
    endtask

    initial begin
        bus.clk_in  = 1'b0;
        bus.err_clr = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        chk_reset_vals("rst0");
        rst = 1'b0;

        // Nominal: first edge only starts timing; lock on the 5th edge.
        step(50, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(EXP_HALF, 1'b1, 1'b0);
        chk("nom_not_locked_yet", 32'(bus.locked), 32'd0);
        step(EXP_HALF, 1'b1, 1'b0);
        chk("nom_locked", 32'(bus.locked), 32'd1);
        chk("nom_errh", 32'(bus.err_high), 32'd0);
        chk("nom_errl", 32'(bus.err_low), 32'd0);

        // Tolerance edges, inclusive.
        step(EXP_HALF + TOL, 1'b1, 1'b0);
        step(EXP_HALF - TOL, 1'b1, 1'b0);
        chk("tol_locked", 32'(bus.locked), 32'd1);
        chk("tol_errh", 32'(bus.err_high), 32'd0);
        chk("tol_errl", 32'(bus.err_low), 32'd0);

        // Just outside high.
        step(EXP_HALF + TOL + 1, 1'b1, 1'b0);
        chk("hi_errh", 32'(bus.err_high), 32'd1);
        chk("hi_errl", 32'(bus.err_low), 32'd0);
        chk("hi_unlock", 32'(bus.locked), 32'd0);

        // Clear alone; half_period untouched.
        pulse_clr();
        chk("clr_errh", 32'(bus.err_high), 32'd0);
        chk("clr_half_hold", bus.half_period, 32'(EXP_HALF + TOL + 1));

        // Just outside low.
        step(EXP_HALF - TOL - 1, 1'b1, 1'b0);
        chk("lo_errl", 32'(bus.err_low), 32'd1);
        chk("lo_errh", 32'(bus.err_high), 32'd0);

        // Clear coinciding with a new high error: old low flag clears, new high stays.
        step(EXP_HALF + TOL + 1, 1'b1, 1'b1);
        chk("clrrace_errh", 32'(bus.err_high), 32'd1);
        chk("clrrace_errl", 32'(bus.err_low), 32'd0);

        // Relock, then stop the clock.
        for (int i = 0; i < LOCK_N; i++) step(EXP_HALF, 1'b1, 1'b0);
        chk("relock", 32'(bus.locked), 32'd1);
        while (elapsed < TIMEOUT + 2) tick();
        chk("to_early", 32'(bus.timeout), 32'd0);
        chk("to_early_locked", 32'(bus.locked), 32'd1);
        tick();
        chk("to_set", 32'(bus.timeout), 32'd1);
        chk("to_unlock", 32'(bus.locked), 32'd0);
        chk("to_half_hold", bus.half_period, 32'(EXP_HALF));

        // After a stop the next edge only restarts timing.
        step(500, 1'b0, 1'b0);
        step(EXP_HALF, 1'b1, 1'b0);

        // Edge landing in the timeout cycle: measurement wins.
        pulse_clr();
        chk("race_pre_to", 32'(bus.timeout), 32'd0);
        chk("race_pre_errh", 32'(bus.err_high), 32'd0);
        step(TIMEOUT, 1'b1, 1'b0);
        chk("race_no_to", 32'(bus.timeout), 32'd0);
        chk("race_errh", 32'(bus.err_high), 32'd1);
        step(EXP_HALF, 1'b1, 1'b0);

        // Reset while locked, partway into a period, with clk_in low.
        for (int i = 0; i < LOCK_N - 1; i++) step(EXP_HALF, 1'b1, 1'b0);
        if (bus.clk_in) step(EXP_HALF, 1'b1, 1'b0);
        chk("prerst_locked", 32'(bus.locked), 32'd1);
        while (elapsed < EXP_HALF / 2) tick();
        rst = 1'b1;
        tick();
        chk_reset_vals("rst1");
        rst = 1'b0;
        step(70, 1'b0, 1'b0);
        step(EXP_HALF, 1'b1, 1'b0);
        chk("postrst_locked", 32'(bus.locked), 32'd0);

        repeat (5) tick();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
